// File: rtl/mem_requester_if.sv
// ---------------------------------------------------------------------------
// mem_requester_if : core request/response channels plus memory-side signals.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface mem_requester_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 2
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_adr;
  logic [DATA_W-1:0] req_wdata;
  logic [LEN_W-1:0]  req_len;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [ADDR_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wen;
  logic              mem_read;
  logic [DATA_W-1:0] mem_res;

  // master: the surrounding system (core plus memory); slave: the requester
  modport master (
    output req_valid, req_we, req_adr, req_wdata, req_len, rsp_ready, mem_res,
    input  req_ready, rsp_valid, rsp_data, mem_adr, mem_data, mem_wen, mem_read
  );

  modport slave (
    input  req_valid, req_we, req_adr, req_wdata, req_len, rsp_ready, mem_res,
    output req_ready, rsp_valid, rsp_data, mem_adr, mem_data, mem_wen, mem_read
  );
endinterface

`default_nettype wire

// File: rtl/mem_requester.sv
// ---------------------------------------------------------------------------
// mem_requester : initiator for a 32x8 registered-read memory with read bursts.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mem_requester #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 2
) (
  input  wire logic       clk,
  input  wire logic       rst,
  mem_requester_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR       = 3'd1,
    S_RD_ISSUE = 3'd2,
    S_RD_WAIT  = 3'd3,
    S_RSP      = 3'd4
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_mem_adr;
  logic [DATA_W-1:0] r_mem_data;
  logic              r_mem_wen;
  logic              r_mem_read;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic [LEN_W-1:0]  r_remaining;

  assign bus.req_ready = (r_state == S_IDLE) && !rst;
  assign bus.mem_adr   = r_mem_adr;
  assign bus.mem_data  = r_mem_data;
  assign bus.mem_wen   = r_mem_wen;
  assign bus.mem_read  = r_mem_read;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mem_adr   <= '0;
      r_mem_data  <= '0;
      r_mem_wen   <= 1'b0;
      r_mem_read  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_remaining <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_mem_adr <= bus.req_adr;
            if (bus.req_we) begin
              r_mem_data <= bus.req_wdata;
              r_mem_wen  <= 1'b1;
              r_state    <= S_WR;
            end else begin
              r_remaining <= bus.req_len;
              r_mem_read  <= 1'b1;
              r_state     <= S_RD_ISSUE;
            end
          end
        end
        S_WR: begin
          r_mem_wen <= 1'b0;
          r_state   <= S_IDLE;
        end
        S_RD_ISSUE: begin
          r_mem_read <= 1'b0;
          r_state    <= S_RD_WAIT;
        end
        // Memory output is valid only in this cycle; capture it at its end.
        S_RD_WAIT: begin
          r_rsp_data  <= bus.mem_res;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RSP;
        end
        S_RSP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (r_remaining == '0) begin
              r_state <= S_IDLE;
            end else begin
              r_remaining <= r_remaining - LEN_W'(1);
              r_mem_adr   <= r_mem_adr + ADDR_W'(1);
              r_mem_read  <= 1'b1;
              r_state     <= S_RD_ISSUE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_requester.sv
// ---------------------------------------------------------------------------
// tb_mem_requester : directed scenarios plus random traffic against a timed model.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_requester;

  localparam int BIG = 32'h3fff_ffff;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic rr_val = 1'b1;
  logic rr_rand = 1'b0;

  mem_requester_if #(.ADDR_W(5), .DATA_W(8), .LEN_W(2)) bus ();

  mem_requester #(.ADDR_W(5), .DATA_W(8), .LEN_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pre(input int i);
    return 8'(i * 37 + 157);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Physical memory: registered read; output is junk outside the read-response cycle.
  logic [7:0] mem [32];
  logic       mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 32; i++) mem[i] <= pre(i);
      mem_loaded <= 1'b1;
    end else if (bus.mem_wen) begin
      mem[bus.mem_adr] <= bus.mem_data;
    end
    bus.mem_res <= bus.mem_read ? mem[bus.mem_adr] : 8'($urandom);
  end

  initial begin
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bus.rsp_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_val;
    end
  end

  // Timed transaction model: each event is scheduled at an absolute cycle number.
  logic [7:0] ref_mem [32];
  logic       ref_loaded = 1'b0;
  int         m_wen_at = -1;
  int         m_read_at = -1;
  int         m_rsp_at = -1;
  int         m_free_at = 0;
  int         m_rem = 0;
  logic [4:0] m_adr = 5'd0;
  logic [7:0] m_mdata = 8'd0;
  logic [7:0] m_rsp_data = 8'd0;

  always @(negedge clk) begin
    int   k;
    logic e_ready, e_wen, e_read, e_rv;
    if (!ref_loaded) begin
      for (int i = 0; i < 32; i++) ref_mem[i] = pre(i);
      ref_loaded = 1'b1;
    end
    if (cyc >= 1) begin
      k       = cyc;
      e_ready = !rst && (k >= m_free_at);
      e_wen   = (k == m_wen_at);
      e_read  = (k == m_read_at);
      e_rv    = (m_rsp_at >= 0) && (k >= m_rsp_at);
      if (e_rv) m_rsp_data = ref_mem[m_adr];
      chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
      chk("mem_wen",   32'(bus.mem_wen),   32'(e_wen));
      chk("mem_read",  32'(bus.mem_read),  32'(e_read));
      chk("mem_adr",   32'(bus.mem_adr),   32'(m_adr));
      chk("mem_data",  32'(bus.mem_data),  32'(m_mdata));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
      chk("rsp_data",  32'(bus.rsp_data),  32'(m_rsp_data));
      if (rst) begin
        m_wen_at = -1; m_read_at = -1; m_rsp_at = -1; m_free_at = 0;
        m_rem = 0; m_adr = 5'd0; m_mdata = 8'd0; m_rsp_data = 8'd0;
      end else begin
        if (e_ready && bus.req_valid) begin
          m_adr = bus.req_adr;
          if (bus.req_we) begin
            m_wen_at  = k + 1;
            m_mdata   = bus.req_wdata;
            ref_mem[bus.req_adr] = bus.req_wdata;
            m_free_at = k + 2;
          end else begin
            m_read_at = k + 1;
            m_rsp_at  = k + 3;
            m_rem     = int'(bus.req_len);
            m_free_at = BIG;
          end
        end
        if (e_rv && bus.rsp_ready) begin
          if (m_rem == 0) begin
            m_rsp_at  = -1;
            m_free_at = k + 1;
          end else begin
            m_rem     = m_rem - 1;
            m_adr     = 5'((int'(m_adr) + 1) % 32);
            m_read_at = k + 1;
            m_rsp_at  = k + 3;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic we, input logic [4:0] a, input logic [7:0] d,
                        input logic [1:0] l, output int acc);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_adr   = a;
    bus.req_wdata = d;
    bus.req_len   = l;
    acc = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        acc = cyc + 1;
        break;
      end
    end
    if (acc < 0) chk("req_accept_timeout", 32'd0, 32'd1);
    step();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
  endtask

  task automatic wait_rsp(output int t, output logic [7:0] d);
    t = -1;
    d = 8'd0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (bus.rsp_valid && bus.rsp_ready) begin
        t = cyc;
        d = bus.rsp_data;
        break;
      end
    end
    if (t < 0) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         acc, acc2, t, tp;
    logic [7:0] d;
    logic [7:0] burst_exp [4];
    burst_exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_adr = '0;
    bus.req_wdata = '0;   bus.req_len = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Preloaded word, single beat
    do_req(1'b0, 5'd0, 8'd0, 2'd0, acc);
    wait_rsp(t, d);
    chk("rd_latency", 32'(t - acc), 32'd2);
    chk("rd_adr0_data", 32'(d), 32'h9D);

    // Reset during RD_WAIT of the first beat of a 4-beat burst
    step();
    do_req(1'b0, 5'd5, 8'd0, 2'd3, acc);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
    chk("rst_mem_adr",   32'(bus.mem_adr),   32'd0);
    chk("rst_mem_read",  32'(bus.mem_read),  32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    repeat (8) step();
    do_req(1'b0, 5'd0, 8'd0, 2'd0, acc);
    wait_rsp(t, d);
    chk("post_rst_data", 32'(d), 32'h9D);

    // Write then read back
    step();
    do_req(1'b1, 5'd31, 8'hBB, 2'd0, acc);
    @(negedge clk);
    chk("wr_wen",  32'(bus.mem_wen),  32'd1);
    chk("wr_adr",  32'(bus.mem_adr),  32'd31);
    chk("wr_data", 32'(bus.mem_data), 32'hBB);
    @(negedge clk);
    chk("wr_wen_off",  32'(bus.mem_wen),   32'd0);
    chk("wr_ready_back", 32'(bus.req_ready), 32'd1);
    step();
    do_req(1'b0, 5'd31, 8'd0, 2'd0, acc);
    wait_rsp(t, d);
    chk("rdback_31", 32'(d), 32'hBB);

    // Wrapping burst 30,31,0,1
    step();
    do_req(1'b1, 5'd30, 8'h11, 2'd0, acc);
    do_req(1'b1, 5'd31, 8'h22, 2'd0, acc);
    do_req(1'b1, 5'd0,  8'h33, 2'd0, acc);
    do_req(1'b1, 5'd1,  8'h44, 2'd0, acc);
    do_req(1'b0, 5'd30, 8'd0,  2'd3, acc);
    tp = acc - 1;
    for (int b = 0; b < 4; b++) begin
      wait_rsp(t, d);
      chk("burst_data", 32'(d), 32'(burst_exp[b]));
      chk("burst_gap", 32'(t - tp), (b == 0) ? 32'd3 : 32'd3);
      tp = t;
    end

    // Backpressure on a 2-beat burst
    step();
    rr_val = 1'b0;
    do_req(1'b0, 5'd2, 8'd0, 2'd1, acc);
    repeat (3) @(negedge clk);
    chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("bp_data",  32'(bus.rsp_data),  32'(pre(2)));
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_no_read",    32'(bus.mem_read),  32'd0);
    end
    rr_val = 1'b1;
    wait_rsp(t, d);
    chk("bp_beat0", 32'(d), 32'(pre(2)));
    wait_rsp(t, d);
    chk("bp_beat1", 32'(d), 32'(pre(3)));

    // Write held while a read is stalled
    step();
    rr_val = 1'b0;
    do_req(1'b0, 5'd4, 8'd0, 2'd0, acc);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_adr = 5'd9; bus.req_wdata = 8'h5A;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("busy_ready", 32'(bus.req_ready), 32'd0);
      chk("busy_wen",   32'(bus.mem_wen),   32'd0);
    end
    rr_val = 1'b1;
    step();
    do_req(1'b1, 5'd9, 8'h5A, 2'd0, acc2);
    do_req(1'b0, 5'd9, 8'd0, 2'd0, acc);
    wait_rsp(t, d);
    chk("busy_write_data", 32'(d), 32'h5A);

    // Random traffic with random backpressure and occasional resets
    step();
    rr_rand = 1'b1;
    for (int i = 0; i < 150; i++) begin
      do_req(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
             8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), acc);
      if (i % 25 == 13) begin
        repeat ($urandom_range(0, 4)) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
      repeat ($urandom_range(0, 2)) step();
    end
    rr_rand = 1'b0;
    rr_val  = 1'b1;
    repeat (30) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
